// File: rtl/fp_mac_accumulator.sv
// Streaming fixed-point dot-product engine: registered product, rounded accumulate,
// and a saturated W-bit result that is held until downstream accepts it.
module fp_mac_accumulator #(
  parameter int SIGNED   = 1,
  parameter int INTEGER  = 2,
  parameter int FRACTION = 14,
  parameter int GUARD    = 4,
  localparam int W       = INTEGER + FRACTION,
  localparam int ACC_W   = 2 * INTEGER + FRACTION + GUARD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_overflow,
  output logic [7:0]   out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

  localparam logic [2*W-1:0] RND = (2*W)'(1) << (FRACTION - 1);

  state_t                r_state;
  logic                  r_drain;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [2*W-1:0]        r_p;
  logic                  r_p_valid;
  logic                  r_p_last;
  logic [ACC_W-1:0]      r_acc;
  logic [W-1:0]          r_out_data;
  logic                  r_out_ovf;
  logic [7:0]            r_count;

  logic                  w_accept;
  logic [2*W-1:0]        w_a_ext;
  logic [2*W-1:0]        w_b_ext;
  logic [2*W-1:0]        w_prod;
  logic [2*W-1:0]        w_rnd;
  logic signed [2*W-1:0] w_shift_s;
  logic [2*W-1:0]        w_shift_u;
  logic [2*W-1:0]        w_shift;
  logic [ACC_W-1:0]      w_s;
  logic [ACC_W-1:0]      w_sum;
  logic [W-1:0]          w_sat_data;
  logic                  w_sat_ovf;

  assign w_accept = in_valid && r_in_ready;

  // Extending both operands to 2W first makes one unsigned multiply serve both number formats.
  assign w_a_ext = (SIGNED != 0) ? {{W{in_a[W-1]}}, in_a} : {{W{1'b0}}, in_a};
  assign w_b_ext = (SIGNED != 0) ? {{W{in_b[W-1]}}, in_b} : {{W{1'b0}}, in_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_rnd     = r_p + RND;
  assign w_shift_s = $signed(w_rnd) >>> FRACTION;
  assign w_shift_u = w_rnd >> FRACTION;
  assign w_shift   = (SIGNED != 0) ? w_shift_s : w_shift_u;
  assign w_s       = ACC_W'(w_shift);
  assign w_sum     = r_acc + w_s;

  // In range only when every bit above the result's sign position agrees with it.
  always_comb begin
    w_sat_ovf  = 1'b0;
    w_sat_data = w_sum[W-1:0];
    if (SIGNED != 0) begin
      if (!((&w_sum[ACC_W-1:W-1]) || !(|w_sum[ACC_W-1:W-1]))) begin
        w_sat_ovf  = 1'b1;
        w_sat_data = w_sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
    end else if (|w_sum[ACC_W-1:W]) begin
      w_sat_ovf  = 1'b1;
      w_sat_data = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_drain     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            if (in_last) begin
              r_state    <= DRAIN;
              r_drain    <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state     <= RESULT;
            r_out_valid <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        RESULT: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p        <= '0;
      r_p_valid  <= 1'b0;
      r_p_last   <= 1'b0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_p_valid <= w_accept;
      r_p_last  <= w_accept && in_last;
      if (w_accept) begin
        r_p <= w_prod;
        if (r_state == IDLE) begin
          r_count <= 8'd1;
        end else if (r_count != 8'hFF) begin
          r_count <= r_count + 8'd1;
        end
      end
      if (r_p_valid) begin
        if (r_p_last) begin
          r_acc      <= '0;
          r_out_data <= w_sat_data;
          r_out_ovf  <= w_sat_ovf;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_overflow = r_out_ovf;
  assign out_count    = r_count;

endmodule

// File: tb/tb_fp_mac_accumulator.sv
// Scoreboard bench for fp_mac_accumulator: directed beats push hand-computed results,
// an independent monitor pops and compares each presented result and its latency.
module tb_fp_mac_accumulator;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic [7:0]  count;
    int          validCycle;
  } expT;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_overflow;
  logic [7:0]  out_count;

  expT expQ[$];
  int  checkCount = 0;
  int  failCount  = 0;
  int  cycleCnt   = 0;
  bit  prevValid  = 1'b0;

  fp_mac_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_overflow(out_overflow), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Drives one beat from a falling edge and holds it until accepted; a last beat queues its expected result.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic last,
                               input logic [15:0] expData, input logic expOvf, input logic [7:0] expCount);
    int waitCycles = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      reportTimeout("beat_accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (last) expQ.push_back('{data: expData, ovf: expOvf, count: expCount, validCycle: cycleCnt + 2});
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 16'hDEAD;
      in_b     = 16'hBEEF;
    end
  endtask

  task automatic waitDrain();
    int waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() != 0) reportTimeout("result_drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic checkZeroed(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_out_overflow"}, 32'(out_overflow), 32'd0);
    checkOutput({tag, "_out_count"}, 32'(out_count), 32'd0);
  endtask

  // Samples just before each rising edge, when both DUT outputs and bench inputs are settled.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL unexpected_result: got data 0x%0h, expected no result", out_data);
        end else begin
          checkOutput("latency_cycle", 32'(cycleCnt), 32'(expQ[0].validCycle));
        end
      end
      if (out_valid && out_ready && expQ.size() != 0) begin
        expT e;
        e = expQ.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("out_overflow", 32'(out_overflow), 32'(e.ovf));
        checkOutput("out_count", 32'(out_count), 32'(e.count));
      end
      prevValid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkZeroed("reset");

    $display("[TB] two-beat vector 1.0*1.0 + 0.5*0.5");
    applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h0, 1'b0, 8'd0);
    applyStimulus(16'h2000, 16'h2000, 1'b1, 16'h5000, 1'b0, 8'd2);
    waitDrain();

    $display("[TB] four beats of 1.5*1.5 saturate");
    for (int i = 0; i < 4; i++)
      applyStimulus(16'h6000, 16'h6000, (i == 3), 16'h7FFF, 1'b1, 8'd4);
    waitDrain();

    $display("[TB] single-beat vectors");
    applyStimulus(16'hC000, 16'h4000, 1'b1, 16'hC000, 1'b0, 8'd1);
    waitDrain();
    applyStimulus(16'h0001, 16'h2000, 1'b1, 16'h0001, 1'b0, 8'd1);
    waitDrain();

    $display("[TB] result stalled by downstream");
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(16'h4000, 16'h4000, 1'b1, 16'h4000, 1'b0, 8'd1);
    waitCycles = 0;
    while (!out_valid && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!out_valid) reportTimeout("stall_out_valid");
    in_valid = 1'b1;
    in_a     = 16'h7FFF;
    in_b     = 16'h7FFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_out_data", 32'(out_data), 32'h4000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_handshake_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_handshake_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDrain();

    $display("[TB] reset in the middle of a vector");
    applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h0, 1'b0, 8'd0);
    applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkZeroed("midreset");
    applyStimulus(16'h4000, 16'h4000, 1'b1, 16'h4000, 1'b0, 8'd1);
    waitDrain();

    $display("[TB] bubbles between beats");
    applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h0, 1'b0, 8'd0);
    idleCycles(3);
    applyStimulus(16'h2000, 16'h2000, 1'b1, 16'h5000, 1'b0, 8'd2);
    waitDrain();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fp_mac_accumulator.md
FP_MAC_ACCUMULATOR -- requirements
Module: fp_mac_accumulator

Interface
REQ-001 Parameters SHALL be:
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- INTEGER, 2, integer bits per operand.
- FRACTION, 14, fraction bits per operand.
- GUARD, 4, extra accumulator headroom bits.

REQ-002 W SHALL denote INTEGER+FRACTION, and ACC_W SHALL denote 2*INTEGER+FRACTION+GUARD.

REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  W  operand A, Q(INTEGER).(FRACTION).
- in_b  in  W  operand B, same format.
- in_last  in  1  beat is the final element of the vector.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  saturated dot-product, same format as the operands.
- out_overflow  out  1  saturation occurred for this vector.
- out_count  out  8  beats in the vector, saturating at 255.

Function
REQ-004 A beat SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.

REQ-005 Stage 1 SHALL register the full product P = in_a*in_b (2W bits, signed or unsigned per SIGNED).

REQ-006 Stage 2 SHALL form the scaled product S = (P + 2^(FRACTION-1)) arithmetic-shifted right by FRACTION (logical shift if SIGNED=0), sign- or zero-extend S to ACC_W, and add it to the accumulator.

REQ-007 The accumulator SHALL NOT wrap within ACC_W for vectors of up to 2^GUARD beats at full-scale operands.

REQ-008 When the stage-2 beat carries last, the block SHALL register out_data = saturate(acc + S) to W bits and clear the accumulator to 0 in the same edge.

REQ-009 Saturation SHALL clamp to 0x7FFF/0x8000 (SIGNED=1) or 0xFFFF (SIGNED=0) and set out_overflow=1; otherwise out_overflow=0.

REQ-010 Latency: a last beat accepted at edge E0 SHALL produce out_valid=1 immediately after edge E2.

REQ-011 The FSM SHALL have the states IDLE, ACCUM, DRAIN and RESULT.
- IDLE: in_ready=1, accumulator 0; a non-last accept goes to ACCUM; a last accept goes to DRAIN.
- ACCUM: in_ready=1; a last accept goes to DRAIN.
- DRAIN: in_ready=0; two cycles, then RESULT.
- RESULT: in_ready=0, out_valid=1; out_valid&&out_ready goes to IDLE.

REQ-012 While in RESULT, out_data, out_overflow and out_count SHALL remain stable until out_ready=1.

REQ-013 in_ready SHALL return to 1 in the cycle after the output handshake; no new beat SHALL be accepted in the same cycle as the output handshake.

REQ-014 A bubble (in_valid=0) inside a vector SHALL leave the accumulator and the count unchanged.

REQ-015 in_a/in_b values presented while in_ready=0 SHALL be ignored.

REQ-016 out_count SHALL increment per accepted beat, saturate at 255, and reset to 0 at the start of each new vector.

REQ-017 A single-beat vector (in_last on the first beat) SHALL produce the rounded, saturated product with out_count=1.

Reset
REQ-018 When rst=1 at a rising edge, the block SHALL set state IDLE, accumulator 0, pipeline valids 0, out_valid 0, out_data 0, out_overflow 0, out_count 0, and in_ready 1 after that edge.

REQ-019 rst SHALL take priority over every other input.

REQ-020 Reset mid-vector or in RESULT SHALL discard partial results; the first beat after reset SHALL start a fresh vector.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- (0x4000,0x4000) then (0x2000,0x2000,last) -> out_data=0x5000, overflow=0, count=2, out_valid after E2 of the last beat.
- Four beats (0x6000,0x6000), last on the 4th -> out_data=0x7FFF, overflow=1, count=4.
- Single beat (0xC000,0x4000,last) -> out_data=0xC000, overflow=0, count=1; rounding beat (0x0001,0x2000,last) -> out_data=0x0001.
- Result pending with out_ready=0 for 5 cycles, in_valid held high -> out_data stable, in_ready=0, no beat consumed; out_ready=1 -> handshake, in_ready=1 the next cycle.
- rst asserted after 2 of 3 beats -> outputs zeroed; new vector (0x4000,0x4000,last) -> out_data=0x4000, count=1.
- Bubbles of 3 idle cycles between beats of the first scenario -> identical result 0x5000.
